// File: rtl/param_memory_unit.sv
// rtl/param_memory_unit.sv - parameterised word memory with self-initialisation and registered reads
module param_memory_unit #(
    parameter int                    DATA_WIDTH = 4,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  addr_err,
    output logic                  init_done
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  addr_in_range;
    logic                  accept;
    logic                  accept_rd;
    logic                  accept_wr;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] rd_word;

    assign addr_in_range = {1'b0, address} < DEPTH_EXT;

    // A clear in the same cycle blocks acceptance, so req_ready drops combinationally.
    assign req_ready = (state == ST_READY) && !clear;
    assign accept    = req_valid && req_ready;
    assign accept_rd = accept && !write_enable;
    assign accept_wr = accept && write_enable && addr_in_range;

    // Next-state logic: INIT sweeps the array once, clear always sends us back to INIT.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT: begin
                if (clear) begin
                    next_state = ST_INIT;
                end else if (ptr == LAST_PTR) begin
                    next_state = ST_READY;
                end
            end
            ST_READY: begin
                if (clear) begin
                    next_state = ST_INIT;
                end
            end
            default: next_state = ST_INIT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // Init pointer: advances only while sweeping; parked at 0 otherwise so a clear restarts at word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == ST_INIT && !clear && ptr != LAST_PTR) begin
            ptr <= ptr + 1'b1;
        end else begin
            ptr <= '0;
        end
    end

    // Single write port shared between the init sweep and accepted in-range writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = data_in;
        if (state == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = ptr;
            mem_wdata = INIT_VALUE;
        end else if (accept_wr) begin
            mem_we = 1'b1;
        end
    end

    // Array storage has no reset; its contents are defined by the init sweep.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read mux: out-of-range addresses return zero.
    always_comb begin
        rd_word = '0;
        if (addr_in_range) begin
            rd_word = mem[address];
        end
    end

    // Registered read path and status pulses; data_out holds unless a read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            rd_valid  <= 1'b0;
            addr_err  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rd_valid  <= accept_rd;
            addr_err  <= accept && !addr_in_range;
            init_done <= (next_state == ST_READY);
            if (accept_rd) begin
                data_out <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_param_memory_unit.sv
// tb/tb_param_memory_unit.sv - randomized model-checked bench for param_memory_unit
module tb_param_memory_unit;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       clear        = 1'b0;
    logic       req_valid    = 1'b0;
    logic       write_enable = 1'b0;
    logic [3:0] address      = 4'h0;
    logic [3:0] data_in      = 4'h0;

    logic [1:0]      rr;
    logic [1:0]      rv;
    logic [1:0]      ae;
    logic [1:0]      idn;
    logic [1:0][3:0] dout;

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  chk_on = 1'b0;

    always #5 clk = ~clk;

    param_memory_unit #(
        .DATA_WIDTH(4), .ADDR_WIDTH(4), .DEPTH(16), .INIT_VALUE(4'h0)
    ) u_def (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid),
        .req_ready(rr[0]), .write_enable(write_enable), .address(address),
        .data_in(data_in), .data_out(dout[0]), .rd_valid(rv[0]),
        .addr_err(ae[0]), .init_done(idn[0])
    );

    param_memory_unit #(
        .DATA_WIDTH(4), .ADDR_WIDTH(4), .DEPTH(12), .INIT_VALUE(4'h9)
    ) u_d12 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid),
        .req_ready(rr[1]), .write_enable(write_enable), .address(address),
        .data_in(data_in), .data_out(dout[1]), .rd_valid(rv[1]),
        .addr_err(ae[1]), .init_done(idn[1])
    );

    // Reference model: per instance, an in-service flag, cycles of init left, and a word array.
    int         mdepth[2] = '{16, 12};
    logic [3:0] minit[2]  = '{4'h0, 4'h9};
    logic [3:0] mmem[2][16];
    logic [3:0] e_dout[2] = '{4'h0, 4'h0};
    bit         e_rv[2]   = '{1'b0, 1'b0};
    bit         e_err[2]  = '{1'b0, 1'b0};
    bit         m_rdy[2]  = '{1'b0, 1'b0};
    int         init_left[2] = '{16, 12};

    function automatic void chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, got, exp, $time);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_rdy[i]     = 1'b0;
                init_left[i] = mdepth[i];
                e_rv[i]      = 1'b0;
                e_err[i]     = 1'b0;
                e_dout[i]    = 4'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!m_rdy[i]) begin
                    e_rv[i]  = 1'b0;
                    e_err[i] = 1'b0;
                    if (clear) begin
                        init_left[i] = mdepth[i];
                    end else begin
                        init_left[i]--;
                        if (init_left[i] == 0) begin
                            m_rdy[i] = 1'b1;
                            for (int j = 0; j < mdepth[i]; j++) mmem[i][j] = minit[i];
                        end
                    end
                end else begin
                    bit acc;
                    bit in_rng;
                    acc      = req_valid && !clear;
                    in_rng   = int'(address) < mdepth[i];
                    e_rv[i]  = acc && !write_enable;
                    e_err[i] = acc && !in_rng;
                    if (acc && !write_enable) e_dout[i] = in_rng ? mmem[i][address] : 4'h0;
                    if (acc && write_enable && in_rng) mmem[i][address] = data_in;
                    if (clear) begin
                        m_rdy[i]     = 1'b0;
                        init_left[i] = mdepth[i];
                    end
                end
            end
        end
    end

    // Compare every output of both instances against the model just after each edge and reset assertion.
    always @(posedge clk or negedge rst_n) begin
        #1;
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                chk("data_out", i, 32'(dout[i]), 32'(e_dout[i]));
                chk("rd_valid", i, 32'(rv[i]), 32'(e_rv[i]));
                chk("addr_err", i, 32'(ae[i]), 32'(e_err[i]));
                chk("init_done", i, 32'(idn[i]), 32'(m_rdy[i]));
                chk("req_ready", i, 32'(rr[i]), 32'(m_rdy[i] && !clear && rst_n));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic we, input logic [3:0] a, input logic [3:0] d);
        req_valid    = 1'b1;
        write_enable = we;
        address      = a;
        data_in      = d;
        step();
    endtask

    task automatic idle();
        req_valid    = 1'b0;
        write_enable = 1'b0;
        step();
    endtask

    task automatic count_init(input string name);
        int first_a;
        int first_b;
        first_a = 0;
        first_b = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (rr[0] && first_a == 0) first_a = k;
            if (rr[1] && first_b == 0) first_b = k;
        end
        chk(name, 0, 32'(first_a), 32'd16);
        chk(name, 1, 32'(first_b), 32'd12);
    endtask

    initial begin
        step();
        chk_on = 1'b1;
        step();
        chk("reset_ready", 0, 32'(rr[0]), 32'd0);
        rst_n = 1'b1;
        count_init("init_cycles");

        for (int a = 0; a < 16; a++) begin
            req(1'b0, 4'(a), 4'h0);
            if (a == 5)  chk("init_word_d12", 5, 32'(dout[1]), 32'h9);
            if (a == 13) chk("oor_read_err", 13, 32'(ae[1]), 32'd1);
            if (a == 13) chk("oor_read_data", 13, 32'(dout[1]), 32'h0);
            if (a == 15) chk("init_word_def", 15, 32'(dout[0]), 32'h0);
        end

        req(1'b1, 4'd0, 4'b1010);
        req(1'b1, 4'd1, 4'b0101);
        req(1'b0, 4'd0, 4'h0);
        chk("b2b_data0", 0, 32'(dout[0]), 32'b1010);
        chk("b2b_valid0", 0, 32'(rv[0]), 32'd1);
        req(1'b0, 4'd1, 4'h0);
        chk("b2b_data1", 0, 32'(dout[0]), 32'b0101);
        chk("b2b_valid1", 0, 32'(rv[0]), 32'd1);
        idle();

        req(1'b1, 4'd3, 4'b1111);
        req(1'b0, 4'd3, 4'h0);
        chk("raw_data", 0, 32'(dout[0]), 32'b1111);
        idle();

        req(1'b1, 4'd13, 4'b0110);
        chk("oor_wr_err", 1, 32'(ae[1]), 32'd1);
        chk("oor_wr_rv", 1, 32'(rv[1]), 32'd0);
        req(1'b0, 4'd13, 4'h0);
        chk("oor_rd_data", 1, 32'(dout[1]), 32'h0);
        req(1'b0, 4'd11, 4'h0);
        chk("oor_intact", 1, 32'(dout[1]), 32'h9);
        idle();

        req(1'b0, 4'd3, 4'h0);
        clear        = 1'b1;
        req_valid    = 1'b1;
        write_enable = 1'b0;
        address      = 4'd13;
        #1;
        chk("clear_ready", 0, 32'(rr[0]), 32'd0);
        step();
        chk("clear_no_rv", 0, 32'(rv[0]), 32'd0);
        chk("clear_no_err", 1, 32'(ae[1]), 32'd0);
        clear     = 1'b0;
        req_valid = 1'b0;
        count_init("clear_cycles");
        chk("clear_hold", 0, 32'(dout[0]), 32'b1111);
        req(1'b0, 4'd0, 4'h0);
        chk("clear_word_def", 0, 32'(dout[0]), 32'h0);
        chk("clear_word_d12", 1, 32'(dout[1]), 32'h9);
        idle();

        req(1'b1, 4'd3, 4'h5);
        req(1'b0, 4'd3, 4'h0);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rv", 0, 32'(rv[0]), 32'd0);
        chk("arst_data", 0, 32'(dout[0]), 32'h0);
        chk("arst_done", 1, 32'(idn[1]), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        count_init("arst_init");

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(599, 0) == 0) begin
                #2;
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            clear        = ($urandom_range(47, 0) == 0);
            req_valid    = ($urandom_range(3, 0) != 0);
            write_enable = 1'($urandom_range(1, 0));
            address      = 4'($urandom_range(15, 0));
            data_in      = 4'($urandom_range(15, 0));
            step();
        end
        clear = 1'b0;
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/param_memory_unit.md
PARAM_MEMORY_UNIT -- requirements
Module: param_memory_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16, number of stored words, legal range 2..2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-bit value written to every word during initialisation.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge except reset.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port clear, input, 1, synchronous request to re-initialise the whole array.
REQ-008 The block SHALL have port req_valid, input, 1, access request present.
REQ-009 The block SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-010 The block SHALL have port write_enable, input, 1, 1 = write, 0 = read; qualified by req_valid.
REQ-011 The block SHALL have port address, input, ADDR_WIDTH, word address of the request.
REQ-012 The block SHALL have port data_in, input, DATA_WIDTH, write data.
REQ-013 The block SHALL have port data_out, output, DATA_WIDTH, registered read data.
REQ-014 The block SHALL have port rd_valid, output, 1, one-cycle pulse marking data_out as new read data.
REQ-015 The block SHALL have port addr_err, output, 1, one-cycle pulse flagging an accepted request with address >= DEPTH.
REQ-016 The block SHALL have port init_done, output, 1, high while the array is initialised and in service.

Function
REQ-017 The block SHALL implement a two-state FSM: INIT and READY.
REQ-018 In INIT, the block SHALL write INIT_VALUE to word ptr each cycle, ptr running 0..DEPTH-1, then move to READY on the next edge; INIT lasts exactly DEPTH cycles.
REQ-019 The block SHALL drive req_ready = (state == READY) and not clear, combinationally.
REQ-020 The block SHALL drive init_done = (state == READY), registered.
REQ-021 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; nothing else changes memory outside INIT.
REQ-022 On an accepted write with address < DEPTH, the block SHALL store data_in at address on that edge; rd_valid SHALL stay 0.
REQ-023 On an accepted read, the block SHALL load data_out and pulse rd_valid in the following cycle; latency is 1 cycle.
REQ-024 Reads SHALL be accepted every cycle; back-to-back reads SHALL produce back-to-back rd_valid pulses.
REQ-025 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-026 When no read is accepted, data_out SHALL hold its last value.
REQ-027 On an accepted request with address >= DEPTH, the block SHALL ignore a write, return all-zero data for a read (rd_valid still pulses), and pulse addr_err 1 cycle after acceptance.
REQ-028 clear = 1 in READY SHALL move the FSM to INIT on the next edge with ptr = 0; a request in the same cycle is not accepted.
REQ-029 clear = 1 during INIT SHALL restart ptr at 0, so INIT completes DEPTH cycles after the last clear.
REQ-030 clear SHALL not modify data_out.

Reset
REQ-031 rst_n = 0 SHALL immediately set state INIT, ptr 0, data_out 0, rd_valid 0, addr_err 0, init_done 0, req_ready 0, regardless of the clock.
REQ-032 After rst_n rises, the block SHALL run a full INIT, so all words read INIT_VALUE.
REQ-033 Reset asserted mid-INIT or mid-read SHALL discard pending rd_valid/addr_err and restart INIT.
REQ-034 Array contents SHALL not be reset directly; they are defined only through INIT.

Verification
REQ-035 Init (defaults): release rst_n -> req_ready 0 for 16 cycles, then init_done 1; reading addresses 0..15 gives 4'b0000.
REQ-036 Write/read: write 4'b1010 to addr 0 and 4'b0101 to addr 1, then read 0 and 1 back to back -> rd_valid high two consecutive cycles, data_out 1010 then 0101.
REQ-037 Read-after-write: write 4'b1111 to addr 3 and read addr 3 on the next cycle -> data_out 1111 one cycle later.
REQ-038 Out-of-range (DEPTH = 12): write 4'b0110 to addr 13, then read addr 13 -> addr_err pulses after each request, read returns 0000, and words 0..11 are unchanged.
REQ-039 Clear: after writes, clear for 1 cycle together with req_valid=1 -> request not accepted, req_ready 0 for DEPTH cycles, then all words read INIT_VALUE and data_out holds its pre-clear value until the next read.
REQ-040 Async reset: drop rst_n between clock edges during a read -> all outputs go 0 immediately, no rd_valid afterwards, and INIT reruns on release.
